// File: rtl/sram_burst_wrapper.sv
// Purpose : AXI3-style burst slave that serves one burst at a time out of a single-port synchronous SRAM.
// Latency : write beats reach the SRAM in the W handshake cycle; first read beat is valid two edges after the AR handshake.
// Backpr. : W is accepted every cycle in WDATA; reads prefetch into a 2-entry buffer, so RREADY low stalls without losing data.
// Ports   : clk/rst_n (async active-low); AW/W/B write channels; AR/R read channels;
//           sram_a word address, sram_web active-low byte write enables, sram_di write data,
//           sram_do read data (valid one cycle after sram_a).
module sram_burst_wrapper #(
  parameter int ID_W    = 8,
  parameter int DATA_W  = 32,
  parameter int SRAM_AW = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_W-1:0]     AWID,
  input  logic [31:0]         AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [31:0]         ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [SRAM_AW-1:0]  sram_a,
  output logic [DATA_W/8-1:0] sram_web,
  output logic [DATA_W-1:0]   sram_di,
  input  logic [DATA_W-1:0]   sram_do
);

  localparam int STRB_W = DATA_W / 8;
  // Byte-offset bits below the word address (also the only legal AxSIZE).
  localparam int LB = (DATA_W == 64) ? 3 : 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_BRESP, ST_RDATA} state_t;

  // WRAP: LEN+1 is a power of two, so LEN itself is the mask of wrapping bits.
  function automatic logic [SRAM_AW-1:0] f_next_addr(input logic [SRAM_AW-1:0] a,
                                                     input logic [1:0]         burst,
                                                     input logic [3:0]         len);
    logic [SRAM_AW-1:0] inc;
    logic [SRAM_AW-1:0] mask;
    inc  = a + SRAM_AW'(1);
    mask = SRAM_AW'(len);
    case (burst)
      BURST_FIXED: f_next_addr = a;
      BURST_WRAP:  f_next_addr = (a & ~mask) | (inc & mask);
      default:     f_next_addr = inc;
    endcase
  endfunction

  function automatic logic f_bad(input logic [2:0] size, input logic [1:0] burst,
                                 input logic [3:0] len);
    f_bad = (burst == 2'b11) || (size != 3'(LB)) ||
            ((burst == BURST_WRAP) &&
             !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15)));
  endfunction

  state_t              r_state;
  logic [ID_W-1:0]     r_id;
  logic [SRAM_AW-1:0]  r_addr;
  logic [3:0]          r_len;
  logic [1:0]          r_burst;
  logic                r_err;
  logic [4:0]          r_wcnt;       // saturates at 16 so overlong bursts stay out of range
  logic [4:0]          r_issued;
  logic                r_inflight;   // SRAM read issued last cycle; sram_do valid now
  logic                r_infl_last;
  logic [1:0]          r_occ;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [DATA_W-1:0]   r_buf_dat [2];
  logic                r_buf_last [2];

  logic                w_aw_hs;
  logic                w_ar_hs;
  logic                w_w_hs;
  logic                w_b_hs;
  logic                w_r_hs;
  logic                w_we;
  logic                w_issue;
  logic [1:0]          w_pend;
  logic                w_unused;

  assign AWREADY  = (r_state == ST_IDLE);
  assign ARREADY  = (r_state == ST_IDLE) && !AWVALID;
  assign WREADY   = (r_state == ST_WDATA);
  assign BVALID   = (r_state == ST_BRESP);
  assign BID      = r_id;
  assign BRESP    = r_err ? RESP_SLVERR : RESP_OKAY;
  assign RVALID   = (r_occ != 2'd0);
  assign RDATA    = r_buf_dat[r_rd_ptr];
  assign RLAST    = RVALID && r_buf_last[r_rd_ptr];
  assign RID      = r_id;
  assign RRESP    = r_err ? RESP_SLVERR : RESP_OKAY;

  assign w_aw_hs  = AWVALID && AWREADY;
  assign w_ar_hs  = ARVALID && ARREADY;
  assign w_w_hs   = WVALID && WREADY;
  assign w_b_hs   = BVALID && BREADY;
  assign w_r_hs   = RVALID && RREADY;

  // Beats beyond LEN+1 and errored bursts never touch the SRAM.
  assign w_we     = w_w_hs && !r_err && (r_wcnt <= {1'b0, r_len});

  // Occupancy plus in-flight may reach 2 only when a pop frees a slot this cycle.
  assign w_pend   = r_occ + {1'b0, r_inflight};
  assign w_issue  = (r_state == ST_RDATA) && (r_issued <= {1'b0, r_len}) &&
                    ((w_pend < 2'd2) || ((w_pend == 2'd2) && w_r_hs));

  // Both directions use the current beat address; only one burst is ever active.
  assign sram_a   = r_addr;
  assign sram_di  = WDATA;
  assign sram_web = w_we ? ~WSTRB : {STRB_W{1'b1}};

  assign w_unused = ^{AWADDR[31:SRAM_AW+LB], AWADDR[LB-1:0],
                      ARADDR[31:SRAM_AW+LB], ARADDR[LB-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_id          <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_burst       <= '0;
      r_err         <= 1'b0;
      r_wcnt        <= '0;
      r_issued      <= '0;
      r_inflight    <= 1'b0;
      r_infl_last   <= 1'b0;
      r_occ         <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_buf_dat[0]  <= '0;
      r_buf_dat[1]  <= '0;
      r_buf_last[0] <= 1'b0;
      r_buf_last[1] <= 1'b0;
    end else begin
      // Read prefetch path; every term here is idle outside RDATA.
      r_inflight <= w_issue;
      if (w_issue) begin
        r_infl_last <= (r_issued == {1'b0, r_len});
        r_issued    <= r_issued + 5'd1;
        r_addr      <= f_next_addr(r_addr, r_burst, r_len);
      end
      if (r_inflight) begin
        r_buf_dat[r_wr_ptr]  <= r_err ? '0 : sram_do;
        r_buf_last[r_wr_ptr] <= r_infl_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_r_hs) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_r_hs};

      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs) begin
            r_id    <= AWID;
            r_addr  <= AWADDR[SRAM_AW+LB-1:LB];
            r_len   <= AWLEN;
            r_burst <= AWBURST;
            r_err   <= f_bad(AWSIZE, AWBURST, AWLEN);
            r_wcnt  <= '0;
            r_state <= ST_WDATA;
          end else if (w_ar_hs) begin
            r_id     <= ARID;
            r_addr   <= ARADDR[SRAM_AW+LB-1:LB];
            r_len    <= ARLEN;
            r_burst  <= ARBURST;
            r_err    <= f_bad(ARSIZE, ARBURST, ARLEN);
            r_issued <= '0;
            r_state  <= ST_RDATA;
          end
        end
        ST_WDATA: begin
          if (w_w_hs) begin
            if (r_wcnt != 5'd16) begin
              r_wcnt <= r_wcnt + 5'd1;
            end
            if (w_we) begin
              r_addr <= f_next_addr(r_addr, r_burst, r_len);
            end
            if (WLAST) begin
              // WLAST must land exactly on beat index LEN.
              if (r_wcnt != {1'b0, r_len}) begin
                r_err <= 1'b1;
              end
              r_state <= ST_BRESP;
            end
          end
        end
        ST_BRESP: begin
          if (w_b_hs) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RDATA: begin
          // The last-tagged entry is always the final one in the buffer.
          if (w_r_hs && r_buf_last[r_rd_ptr]) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_wrapper.sv
// Purpose : scoreboard bench for sram_burst_wrapper with a behavioural SRAM model.
// Latency : SRAM model returns sram_do one edge after sram_a.
// Backpr. : RREADY is driven per test; BREADY is held high.
module tb_sram_burst_wrapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR;
  logic [3:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, ARVALID, ARREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic        BVALID, BREADY;
  logic        RLAST, RVALID, RREADY;
  logic [13:0] sram_a;
  logic [3:0]  sram_web;
  logic [31:0] sram_di, sram_do;

  sram_burst_wrapper #(.ID_W(8), .DATA_W(32), .SRAM_AW(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .sram_a(sram_a), .sram_web(sram_web), .sram_di(sram_di), .sram_do(sram_do)
  );

  always #5 clk = ~clk;

  // SRAM model: word i preloaded with 0x1000_0000 + i.
  logic [31:0] mem [16384];
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h1000_0000 + i;
  end
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (sram_web[b] == 1'b0) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
    sram_do <= mem[sram_a];
  end

  int n_pass  = 0;
  int n_total = 0;
  int b_cnt   = 0;

  logic [49:0] exp_wr [$];   // {addr, data, web}
  logic [9:0]  exp_b  [$];   // {id, resp}
  logic [42:0] exp_r  [$];   // {id, data, resp, last}

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endfunction

  function automatic void fail_evt(string nm, logic [63:0] act);
    n_total++;
    $display("FAIL %s: got 0x%0h expected no event", nm, act);
  endfunction

  function automatic void push_wr(logic [13:0] a, logic [31:0] d, logic [3:0] web);
    exp_wr.push_back({a, d, web});
  endfunction
  function automatic void push_b(logic [7:0] id, logic [1:0] resp);
    exp_b.push_back({id, resp});
  endfunction
  function automatic void push_r(logic [7:0] id, logic [31:0] d, logic [1:0] resp, logic last);
    exp_r.push_back({id, d, resp, last});
  endfunction

  // Monitor: SRAM writes are watched even in reset, channel handshakes only out of reset.
  always @(negedge clk) begin
    if (sram_web !== 4'hF) begin
      if (exp_wr.size() == 0) fail_evt("sram_write", {sram_a, sram_di, sram_web});
      else chk("sram_write", {sram_a, sram_di, sram_web}, exp_wr.pop_front());
    end
    if (rst_n && BVALID && BREADY) begin
      b_cnt++;
      if (exp_b.size() == 0) fail_evt("b_resp", {BID, BRESP});
      else chk("b_resp", {BID, BRESP}, exp_b.pop_front());
    end
    if (rst_n && RVALID && RREADY) begin
      if (exp_r.size() == 0) fail_evt("r_beat", {RID, RDATA, RRESP, RLAST});
      else chk("r_beat", {RID, RDATA, RRESP, RLAST}, exp_r.pop_front());
    end
  end

  task automatic aw_send(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    int n = 0;
    AWID = id; AWADDR = a; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk); ok = AWREADY;
      @(posedge clk); #1; n++;
    end
    AWVALID = 1'b0;
    if (!ok) fail_evt("aw_timeout", 64'(n));
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    int n = 0;
    ARID = id; ARADDR = a; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk); ok = ARREADY;
      @(posedge clk); #1; n++;
    end
    ARVALID = 1'b0;
    if (!ok) fail_evt("ar_timeout", 64'(n));
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] strb, input logic last);
    bit ok = 0;
    int n = 0;
    WDATA = d; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk); ok = WREADY;
      @(posedge clk); #1; n++;
    end
    WVALID = 1'b0;
    if (!ok) fail_evt("w_timeout", 64'(n));
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_wr.size() + exp_b.size() + exp_r.size()) != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    chk(nm, 64'(exp_wr.size() + exp_b.size() + exp_r.size()), 64'd0);
  endtask

  initial begin
    bit          ok;
    bit          prev_stall;
    int          n;
    int          b_before;
    logic [31:0] held;

    rst_n = 1'b1;
    AWVALID = 0; ARVALID = 0; WVALID = 0; BREADY = 1; RREADY = 0;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0;
    WDATA = 0; WSTRB = 0; WLAST = 0;
    #1 rst_n = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_rlast", RLAST, 1'b0);
    chk("rst_bresp", BRESP, 2'b00);
    chk("rst_rresp", RRESP, 2'b00);
    chk("rst_bid", BID, 8'h00);
    chk("rst_rid", RID, 8'h00);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_web", sram_web, 4'hF);
    chk("rst_awready", AWREADY, 1'b1);
    chk("rst_arready", ARREADY, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single partial-strobe write: 0x10 -> word 4, low two bytes
    push_wr(14'd4, 32'hAABBCCDD, 4'b1100);
    push_b(8'h5A, 2'b00);
    aw_send(8'h5A, 32'h10, 4'd0, 3'd2, 2'b01);
    w_send(32'hAABBCCDD, 4'b0011, 1'b1);
    drain("drain_wr_single");

    // INCR read of words 0..3 with latency and no-bubble checks
    RREADY = 1'b1;
    for (int i = 0; i < 4; i++) push_r(8'h21, 32'h1000_0000 + i, 2'b00, i == 3);
    ar_send(8'h21, 32'h0, 4'd3, 3'd2, 2'b01);
    @(negedge clk); chk("rd_lat_e0", RVALID, 1'b0);
    @(negedge clk); chk("rd_lat_e1", RVALID, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("rd_stream", RVALID, 1'b1);
    end
    @(negedge clk);
    chk("rd_end_rvalid", RVALID, 1'b0);
    chk("rd_end_idle", AWREADY, 1'b1);
    drain("drain_rd_incr");

    // WRAP read from word 14 with RREADY toggling
    RREADY = 1'b0;
    push_r(8'h31, 32'h1000_000E, 2'b00, 1'b0);
    push_r(8'h31, 32'h1000_000F, 2'b00, 1'b0);
    push_r(8'h31, 32'h1000_000C, 2'b00, 1'b0);
    push_r(8'h31, 32'h1000_000D, 2'b00, 1'b1);
    ar_send(8'h31, 32'h38, 4'd3, 3'd2, 2'b10);
    prev_stall = 0; held = 0; n = 0;
    while (exp_r.size() != 0 && n < 60) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("r_hold_vld", RVALID, 1'b1);
        chk("r_hold_dat", RDATA, held);
      end
      prev_stall = RVALID && !RREADY;
      held = RDATA;
      @(posedge clk); #1 RREADY = ~RREADY; n++;
    end
    RREADY = 1'b1;
    drain("drain_rd_wrap");

    // Simultaneous AW and AR: write wins, AR only after the B handshake
    push_wr(14'd16, 32'hCAFEF00D, 4'b0000);
    push_b(8'h33, 2'b00);
    push_r(8'h44, 32'h1000_0008, 2'b00, 1'b1);
    AWID = 8'h33; AWADDR = 32'h40; AWLEN = 0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    ARID = 8'h44; ARADDR = 32'h20; ARLEN = 0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    @(negedge clk);
    chk("arb_awready", AWREADY, 1'b1);
    chk("arb_arready", ARREADY, 1'b0);
    @(posedge clk); #1 AWVALID = 1'b0;
    b_before = b_cnt;
    w_send(32'hCAFEF00D, 4'hF, 1'b1);
    ok = 0; n = 0;
    while (!ok && n < 100) begin
      @(negedge clk); ok = ARREADY;
      if (ok) chk("ar_after_b", 64'(b_cnt), 64'(b_before + 1));
      @(posedge clk); #1; n++;
    end
    ARVALID = 1'b0;
    if (!ok) fail_evt("arb_ar_timeout", 64'(n));
    drain("drain_arb");

    // Reserved burst type on a read: two zero beats with SLVERR
    push_r(8'h55, 32'h0, 2'b10, 1'b0);
    push_r(8'h55, 32'h0, 2'b10, 1'b1);
    ar_send(8'h55, 32'h0, 4'd1, 3'd2, 2'b11);
    drain("drain_rd_err");

    // Late WLAST: third beat accepted but not written, SLVERR
    push_wr(14'd32, 32'h11111111, 4'b0000);
    push_wr(14'd33, 32'h22222222, 4'b0000);
    push_b(8'h66, 2'b10);
    aw_send(8'h66, 32'h80, 4'd1, 3'd2, 2'b01);
    w_send(32'h11111111, 4'hF, 1'b0);
    w_send(32'h22222222, 4'hF, 1'b0);
    w_send(32'h33333333, 4'hF, 1'b1);
    drain("drain_wr_late");

    // Early WLAST: single beat written, SLVERR
    push_wr(14'd64, 32'h44444444, 4'b0000);
    push_b(8'h77, 2'b10);
    aw_send(8'h77, 32'h100, 4'd1, 3'd2, 2'b01);
    w_send(32'h44444444, 4'hF, 1'b1);
    drain("drain_wr_early");

    // Wrong SIZE: no SRAM write, SLVERR
    push_b(8'h78, 2'b10);
    aw_send(8'h78, 32'h140, 4'd0, 3'd1, 2'b01);
    w_send(32'h55555555, 4'hF, 1'b1);
    drain("drain_wr_size");

    // Reset during the third beat of a 4-beat write
    push_wr(14'd128, 32'hA0A0A0A0, 4'b0000);
    push_wr(14'd129, 32'hA1A1A1A1, 4'b0000);
    aw_send(8'h88, 32'h200, 4'd3, 3'd2, 2'b01);
    w_send(32'hA0A0A0A0, 4'hF, 1'b0);
    w_send(32'hA1A1A1A1, 4'hF, 1'b0);
    WDATA = 32'hA2A2A2A2; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_web", sram_web, 4'hF);
    chk("mid_rst_bvalid", BVALID, 1'b0);
    repeat (2) @(posedge clk);
    #1 WVALID = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_bvalid", BVALID, 1'b0);
    chk("post_rst_web", sram_web, 4'hF);
    chk("post_rst_awready", AWREADY, 1'b1);
    @(posedge clk); #1;
    drain("drain_rst");

    // Read back SRAM contents left by the earlier writes
    push_r(8'h99, 32'h1000_CCDD, 2'b00, 1'b1);
    ar_send(8'h99, 32'h10, 4'd0, 3'd2, 2'b01);
    drain("drain_rb_word4");
    push_r(8'h9A, 32'h11111111, 2'b00, 1'b0);
    push_r(8'h9A, 32'h22222222, 2'b00, 1'b0);
    push_r(8'h9A, 32'h1000_0022, 2'b00, 1'b1);
    ar_send(8'h9A, 32'h80, 4'd2, 3'd2, 2'b01);
    drain("drain_rb_late");
    push_r(8'h9B, 32'hA0A0A0A0, 2'b00, 1'b0);
    push_r(8'h9B, 32'hA1A1A1A1, 2'b00, 1'b0);
    push_r(8'h9B, 32'h1000_0082, 2'b00, 1'b1);
    ar_send(8'h9B, 32'h200, 4'd2, 3'd2, 2'b01);
    drain("drain_rb_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
